// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI_COMM slave and the frame controller.
//   spi_busy   : frame active (SS low)
//   spi_eob    : one-clk pulse per received byte, spi_rx valid with it
//   spi_rx     : received byte
//   spi_cmd    : register address field of the command byte
//   spi_sec    : bank select field of the command byte
//   spi_read   : read direction field of the command byte
//   spi_format : 1 = burst (auto-increment)
//   spi_tx     : byte to shift out on MISO
//   spi_err    : error flag reported back to SPI_COMM
// master = SPI_COMM side, slave = spi_reg_ctrl side.
interface spi_reg_ctrl_if;
  logic       spi_busy;
  logic       spi_eob;
  logic [7:0] spi_rx;
  logic [4:0] spi_cmd;
  logic       spi_sec;
  logic       spi_read;
  logic       spi_format;
  logic [7:0] spi_tx;
  logic       spi_err;

  modport master (
    output spi_busy, spi_eob, spi_rx, spi_cmd, spi_sec, spi_read, spi_format,
    input  spi_tx, spi_err
  );

  modport slave (
    input  spi_busy, spi_eob, spi_rx, spi_cmd, spi_sec, spi_read, spi_format,
    output spi_tx, spi_err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller behind SPI_COMM. Decodes the command byte of each
// frame and then writes config registers, reads config/status registers or
// pops bytes from the sniffer stream.
//   clk, rst    : system clock, synchronous active-high reset
//   spi         : byte link to SPI_COMM (slave modport)
//   cfg_out     : flattened config registers, reg i at [8i+7:8i]
//   cfg_wr      : one-clk pulse after a config register write
//   cfg_wr_addr : address of that write
//   stat_in     : flattened read-only status registers
//   strm_data   : stream byte, strm_valid = byte available
//   strm_ready  : one-clk pop pulse
module spi_reg_ctrl #(
  parameter int unsigned N_CFG   = 8,
  parameter int unsigned N_STAT  = 8,
  parameter logic [7:0]  CFG_RST = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_ctrl_if.slave         spi,
  output logic [8*N_CFG-1:0]    cfg_out,
  output logic                  cfg_wr,
  output logic [4:0]            cfg_wr_addr,
  input  logic [8*N_STAT-1:0]   stat_in,
  input  logic [7:0]            strm_data,
  input  logic                  strm_valid,
  output logic                  strm_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

  localparam logic [4:0] STRM_ADDR = 5'd31;

  state_t               state_q, state_d;
  logic [4:0]           addr_q, addr_d;
  logic                 bank_q, bank_d;
  logic                 burst_q, burst_d;
  logic                 abort_q, abort_d;
  logic [7:0]           tx_q, tx_d;
  logic                 err_q, err_d;
  logic [8*N_CFG-1:0]   cfg_q, cfg_d;
  logic                 cfg_wr_q, cfg_wr_d;
  logic [4:0]           cfg_wr_addr_q, cfg_wr_addr_d;
  logic                 strm_ready_q, strm_ready_d;

  logic [4:0]           lk_addr;
  logic                 lk_bank;
  logic [7:0]           src_byte;
  logic                 src_pop;
  logic                 src_err;
  logic                 src_hit;
  logic                 wr_hit;

  // The stream address in bank 0 never advances; everything else wraps.
  function automatic logic [4:0] next_addr(input logic [4:0] a, input logic b);
    return (!b && a == STRM_ADDR) ? a : a + 5'd1;
  endfunction

  // Address whose byte is loaded into spi_tx this cycle: the freshly decoded
  // command address in CMD, the incremented address during a burst read.
  always_comb begin
    lk_addr = next_addr(addr_q, bank_q);
    lk_bank = bank_q;
    if (state_q == ST_CMD) begin
      lk_addr = spi.spi_cmd;
      lk_bank = spi.spi_sec;
    end
  end

  always_comb begin
    src_byte = '0;
    src_pop  = 1'b0;
    src_err  = 1'b0;
    src_hit  = 1'b0;
    if (!lk_bank) begin
      for (int unsigned i = 0; i < N_CFG; i++) begin
        if (lk_addr == i[4:0]) begin
          src_byte = cfg_q[8*i +: 8];
          src_hit  = 1'b1;
        end
      end
      if (lk_addr == STRM_ADDR) begin
        src_hit = 1'b1;
        if (strm_valid) begin
          src_byte = strm_data;
          src_pop  = 1'b1;
        end else begin
          src_err  = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_STAT; i++) begin
        if (lk_addr == i[4:0]) begin
          src_byte = stat_in[8*i +: 8];
          src_hit  = 1'b1;
        end
      end
    end
    if (!src_hit) begin
      src_err = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    bank_d        = bank_q;
    burst_d       = burst_q;
    abort_d       = abort_q;
    tx_d          = tx_q;
    err_d         = err_q;
    cfg_d         = cfg_q;
    cfg_wr_d      = 1'b0;
    cfg_wr_addr_d = cfg_wr_addr_q;
    strm_ready_d  = 1'b0;
    wr_hit        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // After a reset the remainder of an interrupted frame is skipped.
        if (abort_q) begin
          if (!spi.spi_busy) begin
            abort_d = 1'b0;
          end
        end else if (spi.spi_busy) begin
          state_d = ST_CMD;
          err_d   = 1'b0;
        end
      end

      ST_CMD: begin
        if (spi.spi_eob) begin
          addr_d  = spi.spi_cmd;
          bank_d  = spi.spi_sec;
          burst_d = spi.spi_format;
          if (spi.spi_read) begin
            state_d      = ST_READ;
            tx_d         = src_byte;
            strm_ready_d = src_pop;
            if (src_err) begin
              err_d = 1'b1;
            end
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (spi.spi_eob) begin
          if (!bank_q) begin
            for (int unsigned i = 0; i < N_CFG; i++) begin
              if (addr_q == i[4:0]) begin
                cfg_d[8*i +: 8] = spi.spi_rx;
                wr_hit          = 1'b1;
              end
            end
          end
          if (wr_hit) begin
            cfg_wr_d      = 1'b1;
            cfg_wr_addr_d = addr_q;
          end else begin
            err_d = 1'b1;
          end
          if (burst_q) begin
            addr_d = next_addr(addr_q, bank_q);
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_READ: begin
        if (spi.spi_eob) begin
          if (burst_q) begin
            addr_d       = lk_addr;
            tx_d         = src_byte;
            strm_ready_d = src_pop;
            if (src_err) begin
              err_d = 1'b1;
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (spi.spi_eob) begin
          err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A byte arriving with the end of the frame is handled above first.
    if (!spi.spi_busy) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      bank_q        <= 1'b0;
      burst_q       <= 1'b0;
      abort_q       <= 1'b1;
      tx_q          <= '0;
      err_q         <= 1'b0;
      cfg_q         <= {N_CFG{CFG_RST}};
      cfg_wr_q      <= 1'b0;
      cfg_wr_addr_q <= '0;
      strm_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      burst_q       <= burst_d;
      abort_q       <= abort_d;
      tx_q          <= tx_d;
      err_q         <= err_d;
      cfg_q         <= cfg_d;
      cfg_wr_q      <= cfg_wr_d;
      cfg_wr_addr_q <= cfg_wr_addr_d;
      strm_ready_q  <= strm_ready_d;
    end
  end

  assign spi.spi_tx  = tx_q;
  assign spi.spi_err = err_q;
  assign cfg_out     = cfg_q;
  assign cfg_wr      = cfg_wr_q;
  assign cfg_wr_addr = cfg_wr_addr_q;
  assign strm_ready  = strm_ready_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: models SPI_COMM at byte level and a
// simple stream FIFO, and checks against hand-computed values.
module tb_spi_reg_ctrl;
  localparam int unsigned N_CFG  = 8;
  localparam int unsigned N_STAT = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [8*N_CFG-1:0]  cfg_out;
  logic                cfg_wr;
  logic [4:0]          cfg_wr_addr;
  logic [8*N_STAT-1:0] stat_in;
  logic [7:0]          strm_data;
  logic                strm_valid;
  logic                strm_ready;

  spi_reg_ctrl_if spi ();

  spi_reg_ctrl #(
    .N_CFG   (N_CFG),
    .N_STAT  (N_STAT),
    .CFG_RST (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi.slave),
    .cfg_out     (cfg_out),
    .cfg_wr      (cfg_wr),
    .cfg_wr_addr (cfg_wr_addr),
    .stat_in     (stat_in),
    .strm_data   (strm_data),
    .strm_valid  (strm_valid),
    .strm_ready  (strm_ready)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [7:0]  strm_fifo[$];
  int unsigned pop_cnt = 0;
  int unsigned wr_cnt  = 0;
  logic [4:0]  wr_addrs[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stream source and write monitor, both sampled on the falling edge.
  always @(negedge clk) begin
    if (strm_ready && strm_valid) begin
      void'(strm_fifo.pop_front());
      pop_cnt++;
    end
    strm_valid = (strm_fifo.size() != 0);
    strm_data  = (strm_fifo.size() != 0) ? strm_fifo[0] : 8'h00;
    if (cfg_wr) begin
      wr_cnt++;
      wr_addrs.push_back(cfg_wr_addr);
    end
  end

  function automatic logic [7:0] cfg_byte(input int unsigned i);
    return cfg_out[8*i +: 8];
  endfunction

  task automatic frame_begin();
    @(negedge clk);
    spi.spi_busy = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (3) @(negedge clk);
    spi.spi_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Delivers one byte; if last is set the frame ends in the same cycle.
  task automatic send_byte(input logic [7:0] b, input bit last = 1'b0);
    repeat (4) @(negedge clk);
    spi.spi_rx     = b;
    spi.spi_cmd    = b[4:0];
    spi.spi_sec    = b[5];
    spi.spi_read   = b[6];
    spi.spi_format = b[7];
    spi.spi_eob    = 1'b1;
    if (last) spi.spi_busy = 1'b0;
    @(negedge clk);
    spi.spi_eob = 1'b0;
  endtask

  logic [63:0] cfg_snap;
  int unsigned wr_base;
  logic [4:0]  a;

  initial begin
    spi.spi_busy   = 1'b0;
    spi.spi_eob    = 1'b0;
    spi.spi_rx     = '0;
    spi.spi_cmd    = '0;
    spi.spi_sec    = 1'b0;
    spi.spi_read   = 1'b0;
    spi.spi_format = 1'b0;
    stat_in        = '0;
    stat_in[7:0]   = 8'h12;
    stat_in[15:8]  = 8'h34;
    stat_in[23:16] = 8'h56;
    strm_valid     = 1'b0;
    strm_data      = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("rst_tx", spi.spi_tx, 8'h00);
    check_eq("rst_err", spi.spi_err, 1'b0);
    check_eq("rst_cfg", cfg_out, 64'h0);
    check_eq("rst_cfg_wr", cfg_wr, 1'b0);
    check_eq("rst_wr_addr", cfg_wr_addr, 5'd0);
    check_eq("rst_strm_ready", strm_ready, 1'b0);

    // Single write 0x03 + 0x96
    frame_begin();
    send_byte(8'h03);
    send_byte(8'h96);
    check_eq("sw_cfg3", cfg_byte(3), 8'h96);
    check_eq("sw_err", spi.spi_err, 1'b0);
    frame_end();
    check_eq("sw_wr_cnt", wr_cnt, 1);
    a = wr_addrs.pop_front();
    check_eq("sw_wr_addr", a, 5'd3);

    // Burst write 0x81 + A5 69 66
    wr_base = wr_cnt;
    frame_begin();
    send_byte(8'h81);
    send_byte(8'hA5);
    send_byte(8'h69);
    send_byte(8'h66);
    frame_end();
    check_eq("bw_cfg1", cfg_byte(1), 8'hA5);
    check_eq("bw_cfg2", cfg_byte(2), 8'h69);
    check_eq("bw_cfg3", cfg_byte(3), 8'h66);
    check_eq("bw_err", spi.spi_err, 1'b0);
    check_eq("bw_wr_cnt", wr_cnt - wr_base, 3);
    for (int k = 1; k <= 3; k++) begin
      a = wr_addrs.pop_front();
      check_eq("bw_wr_addr", a, k[4:0]);
    end

    // Burst read of status bank 0xE0
    frame_begin();
    send_byte(8'hE0);
    check_eq("br_tx0", spi.spi_tx, 8'h12);
    send_byte(8'h00);
    check_eq("br_tx1", spi.spi_tx, 8'h34);
    send_byte(8'h00);
    check_eq("br_tx2", spi.spi_tx, 8'h56);
    check_eq("br_err", spi.spi_err, 1'b0);
    frame_end();

    // Single read of cfg1, then an extra byte lands in DRAIN
    frame_begin();
    send_byte(8'h41);
    check_eq("sr_tx", spi.spi_tx, 8'hA5);
    send_byte(8'h00);
    check_eq("sr_tx_hold", spi.spi_tx, 8'hA5);
    check_eq("sr_err0", spi.spi_err, 1'b0);
    send_byte(8'h00);
    check_eq("sr_drain_err", spi.spi_err, 1'b1);
    frame_end();

    // Stream read 0xDF with two queued bytes
    strm_fifo.push_back(8'hAA);
    strm_fifo.push_back(8'h55);
    repeat (2) @(negedge clk);
    frame_begin();
    check_eq("st_err_clr", spi.spi_err, 1'b0);
    send_byte(8'hDF);
    check_eq("st_tx0", spi.spi_tx, 8'hAA);
    send_byte(8'h00);
    check_eq("st_tx1", spi.spi_tx, 8'h55);
    check_eq("st_err0", spi.spi_err, 1'b0);
    send_byte(8'h00);
    check_eq("st_tx2", spi.spi_tx, 8'h00);
    check_eq("st_err2", spi.spi_err, 1'b1);
    send_byte(8'h00);
    frame_end();
    check_eq("st_pops", pop_cnt, 2);
    check_eq("st_fifo_empty", strm_fifo.size(), 0);

    // Single write with two data bytes
    wr_base = wr_cnt;
    frame_begin();
    send_byte(8'h03);
    send_byte(8'h11);
    check_eq("sw2_err0", spi.spi_err, 1'b0);
    send_byte(8'h22);
    check_eq("sw2_cfg3", cfg_byte(3), 8'h11);
    check_eq("sw2_err1", spi.spi_err, 1'b1);
    frame_end();
    check_eq("sw2_wr_cnt", wr_cnt - wr_base, 1);
    void'(wr_addrs.pop_front());

    // Write to bank 1: no change, error, cleared next frame
    cfg_snap = cfg_out;
    frame_begin();
    check_eq("b1_err_clr_prev", spi.spi_err, 1'b0);
    send_byte(8'h20);
    send_byte(8'h77);
    check_eq("b1_cfg", cfg_out, cfg_snap);
    check_eq("b1_err", spi.spi_err, 1'b1);
    frame_end();
    frame_begin();
    check_eq("b1_err_clr", spi.spi_err, 1'b0);
    // Unmapped cfg address 10
    send_byte(8'h0A);
    send_byte(8'h77);
    check_eq("um_cfg", cfg_out, cfg_snap);
    check_eq("um_err", spi.spi_err, 1'b1);
    frame_end();

    // Burst write at the top of the bank runs into unmapped space
    frame_begin();
    send_byte(8'h87);
    send_byte(8'h71);
    check_eq("top_cfg7", cfg_byte(7), 8'h71);
    check_eq("top_err0", spi.spi_err, 1'b0);
    send_byte(8'h72);
    check_eq("top_err1", spi.spi_err, 1'b1);
    check_eq("top_cfg0", cfg_byte(0), 8'h00);
    frame_end();

    // Data byte arriving with the end of the frame
    frame_begin();
    send_byte(8'h02);
    send_byte(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("eob_end_cfg2", cfg_byte(2), 8'h44);
    frame_end();
    wr_addrs.delete();

    // Reset in the middle of a burst write
    wr_base = wr_cnt;
    frame_begin();
    send_byte(8'h80);
    send_byte(8'hC3);
    check_eq("rm_cfg0_pre", cfg_byte(0), 8'hC3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rm_cfg_rst", cfg_out, 64'h0);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("rm_cfg_ign", cfg_out, 64'h0);
    check_eq("rm_err", spi.spi_err, 1'b0);
    frame_end();
    check_eq("rm_wr_cnt", wr_cnt - wr_base, 1);
    frame_begin();
    send_byte(8'h05);
    send_byte(8'h3C);
    frame_end();
    check_eq("rm_new_cfg5", cfg_byte(5), 8'h3C);
    check_eq("rm_new_cfg", cfg_out, 64'h0000_3C00_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Frame-level controller sitting behind the SPI_COMM slave. It decodes each SPI frame's command byte: CMD address, sec_CMD bank select, read direction and format (single/burst). It then sequences the data bytes that follow, which means writing a bank of configuration registers, reading back config or status registers, or popping bytes from the sniffer data stream. It drives SPI_COMM's transmit byte and error input, so SPI_COMM stays a pure byte transport.

Parameters:
N_CFG, 8, number of 8-bit RW config registers (bank 0, addresses 0..N_CFG-1); max 31
N_STAT, 8, number of 8-bit RO status registers (bank 1, addresses 0..N_STAT-1); max 32
CFG_RST, 0, reset value of every config register (8-bit)

Ports:
clk  in  1  system clock; also clocks SPI_COMM, at least 3x SCLK
rst  in  1  synchronous, active-high reset
spi_busy  in  1  SPI_COMM busy; high while SS is low (frame active)
spi_eob  in  1  SPI_COMM end-of-byte; one-clk pulse per received byte
spi_rx  in  8  SPI_COMM DATA_out; valid when spi_eob=1
spi_cmd  in  5  SPI_COMM CMD (register address)
spi_sec  in  1  SPI_COMM sec_CMD (bank select)
spi_read  in  1  SPI_COMM read flag
spi_format  in  1  SPI_COMM format flag (1 = burst, auto-increment)
spi_tx  out  8  to SPI_COMM DATA_in; byte shifted out on MISO
spi_err  out  1  to SPI_COMM err_in
cfg_out  out  8*N_CFG  flattened config registers, reg i at [8i+7:8i]
cfg_wr  out  1  one-clk pulse when a config register is written
cfg_wr_addr  out  5  address written, valid with cfg_wr
stat_in  in  8*N_STAT  flattened status registers
strm_data  in  8  sniffer stream byte
strm_valid  in  1  stream byte available
strm_ready  out  1  one-clk pop pulse; byte consumed when strm_valid & strm_ready

Behaviour:
- Reset values: all cfg regs = CFG_RST, spi_tx=0x00, spi_err=0, cfg_wr=0, cfg_wr_addr=0, strm_ready=0, state=IDLE.
- A reset asserted mid-frame aborts the frame. The rest of that frame is ignored until spi_busy falls.
- FSM states: IDLE, CMD, WRITE, READ, DRAIN.
- IDLE -> CMD on spi_busy=1. spi_err clears on this transition and is sticky within a frame.
- CMD: on spi_eob, latch addr=spi_cmd, bank=spi_sec, burst=spi_format, rd=spi_read.
  - Go to READ if rd=1, else WRITE.
  - In the same cycle, when rd=1, spi_tx loads the first read byte, so the next clk edge holds it (1-clk latency from eob).
- Any state: spi_busy=0 -> IDLE next cycle. A frame ending in CMD is discarded silently.
- WRITE: on each spi_eob, if bank=0 and addr<N_CFG, cfg[addr]<=spi_rx and cfg_wr/cfg_wr_addr pulse next cycle.
  - burst=1: addr increments after each byte.
  - burst=0: go to DRAIN after the first data byte.
- READ: the byte source for addr is:
  - bank0, addr<N_CFG: cfg[addr]
  - bank1, addr<N_STAT: stat_in[addr]
  - bank0, addr=31: stream pop
  - otherwise 0x00
- READ: on each data spi_eob with burst=1, addr increments and spi_tx loads the next byte in the same cycle.
- READ with burst=0: go to DRAIN; spi_tx holds the last byte.
- Stream pop, with strm_valid=1: spi_tx<=strm_data and strm_ready pulses one clk.
- Stream pop, with strm_valid=0: spi_tx<=0x00 and spi_err<=1.
- The stream address never auto-increments: a burst read at 31 pops once per byte. Initial load at CMD eob counts as a pop.
- Address rules: 5-bit, wraps 31->0 in burst. The stream address 31 is sticky, i.e. it does not wrap.
- Error (spi_err<=1) is raised by:
  - access to an unmapped address
  - a write to bank1
  - a write to address 31
  - extra bytes received in DRAIN
  - a stream underflow
- DRAIN: every spi_eob sets spi_err; no register changes.
- Simultaneous spi_eob and spi_busy falling in the same cycle: the byte is processed first, then the FSM goes to IDLE.

Test Plan:
- Single write: cmd byte 0x03 (addr3, bank0, write, single) + 0x96 -> cfg[3]=0x96, cfg_wr pulse with addr 3, spi_err=0.
- Burst write: 0x81 + 0xA5,0x69,0x66 -> cfg[1..3]=A5,69,66, three cfg_wr pulses, addresses 1,2,3.
- Burst read of bank1: stat_in bytes0..1=0x12,0x34; cmd 0xE0 -> spi_tx=0x12 one clk after cmd eob, 0x34 after the next eob.
- Stream read: two bytes queued (0xAA, 0x55), cmd 0xDF, 3 data bytes -> spi_tx=AA, 55, 00; two strm_ready pulses; spi_err=1 on the third byte.
- Error cases: single write 0x03 with 2 data bytes -> only the first is written, spi_err=1. A write to bank1 (0x20+data) -> no change, spi_err=1, cleared at the next frame start.
- Reset mid-burst write after 1 data byte -> all cfg=CFG_RST, the remaining bytes are ignored, and a new frame after SS high decodes normally.
